// File: rtl/bw_io_bsr_pkg.sv
// Shared types for the DTL boundary-scan master: FSM state encoding and clock phase codes.
package bw_io_bsr_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCap,
      StShift,
      StUpd,
      StResp
   } bsr_state_e;

   localparam logic PhLo = 1'b0;
   localparam logic PhHi = 1'b1;

   // States in which the phase generator runs.
   function automatic logic is_phased(input bsr_state_e st);
      return (st == StCap) || (st == StShift) || (st == StUpd);
   endfunction

endpackage

// File: rtl/bw_io_bsr_clkgen.sv
// Phase generator for the BSR master: CLK_DIV cycles low, CLK_DIV cycles high, with
// one-cycle strobes on the last cycle of each phase. Held in the low phase while disabled.
module bw_io_bsr_clkgen
   import bw_io_bsr_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset_l,
   input  logic i_en,
   output logic o_lo_last,
   output logic o_hi_last
);

   localparam int unsigned CW = $clog2(CLK_DIV) + 1;
   localparam logic [CW-1:0] LP_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] LP_ONE  = CW'(1);

   logic [CW-1:0] r_cnt;
   logic          r_phase;
   logic          w_wrap;

   assign w_wrap = (r_cnt == LP_LAST);

   always_ff @(posedge clk) begin
      if (!reset_l || !i_en) begin
         r_cnt   <= '0;
         r_phase <= PhLo;
      end else if (w_wrap) begin
         r_cnt   <= '0;
         r_phase <= ~r_phase;
      end else begin
         r_cnt   <= r_cnt + LP_ONE;
      end
   end

   assign o_lo_last = i_en && (r_phase == PhLo) && w_wrap;
   assign o_hi_last = i_en && (r_phase == PhHi) && w_wrap;

endmodule

// File: rtl/bw_io_dtl_bsr_master.sv
// Boundary-scan master for one DTL pad group: runs CAPTURE/SHIFT/UPDATE on the BSR chain
// per request and returns the shifted-out word. Optional EXTEST mode via BW_IO_BSR_EXTEST_EN.
module bw_io_dtl_bsr_master
   import bw_io_bsr_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = 8,
   parameter int unsigned CLK_DIV   = 2
) (
   input  logic                 clk,
   input  logic                 reset_l,
   input  logic                 req_vld,
   output logic                 req_rdy,
   input  logic                 req_cap,
   input  logic                 req_upd,
`ifdef BW_IO_BSR_EXTEST_EN
   input  logic                 req_extest,
`endif
   input  logic [CHAIN_LEN-1:0] req_data,
   output logic                 rsp_vld,
   input  logic                 rsp_rdy,
   output logic [CHAIN_LEN-1:0] rsp_data,
   output logic                 shift_dr,
   output logic                 clock_dr,
   output logic                 update_dr,
   output logic                 mode_ctl,
   output logic                 bsr_si,
   input  logic                 bso
);

   localparam int unsigned BW = $clog2(CHAIN_LEN) + 1;
   localparam logic [BW-1:0] LP_BIT_LAST = BW'(CHAIN_LEN - 1);
   localparam logic [BW-1:0] LP_BIT_ONE  = BW'(1);

   bsr_state_e           r_state;
   logic [CHAIN_LEN-1:0] r_shreg;
   logic [CHAIN_LEN-1:0] r_rsp_data;
   logic [BW-1:0]        r_bit;
   logic                 r_upd;
   logic                 r_req_rdy;
   logic                 r_rsp_vld;
   logic                 r_shift_dr;
   logic                 r_clock_dr;
   logic                 r_update_dr;
   logic                 r_bsr_si;
   logic                 w_lo_last;
   logic                 w_hi_last;
   logic [CHAIN_LEN-1:0] w_bso_msb;

   bw_io_bsr_clkgen #(
      .CLK_DIV (CLK_DIV)
   ) u_clkgen (
      .clk       (clk),
      .reset_l   (reset_l),
      .i_en      (is_phased(r_state)),
      .o_lo_last (w_lo_last),
      .o_hi_last (w_hi_last)
   );

   // Each bso sample enters at the MSB so the first sample ends up in bit 0.
   always_comb begin
      w_bso_msb              = '0;
      w_bso_msb[CHAIN_LEN-1] = bso;
   end

`ifdef BW_IO_BSR_EXTEST_EN
   logic r_extest;
   logic r_mode_ctl;
`endif

   always_ff @(posedge clk) begin
      if (!reset_l) begin
         r_state     <= StIdle;
         r_shreg     <= '0;
         r_rsp_data  <= '0;
         r_bit       <= '0;
         r_upd       <= 1'b0;
         r_req_rdy   <= 1'b0;
         r_rsp_vld   <= 1'b0;
         r_shift_dr  <= 1'b0;
         r_clock_dr  <= 1'b0;
         r_update_dr <= 1'b0;
         r_bsr_si    <= 1'b0;
`ifdef BW_IO_BSR_EXTEST_EN
         r_extest    <= 1'b0;
         r_mode_ctl  <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            StIdle: begin
               r_req_rdy <= 1'b1;
               if (req_vld && r_req_rdy) begin
                  r_req_rdy <= 1'b0;
                  r_shreg   <= req_data;
                  r_upd     <= req_upd;
                  r_bit     <= '0;
`ifdef BW_IO_BSR_EXTEST_EN
                  r_extest  <= req_extest;
`endif
                  if (req_cap) begin
                     r_state <= StCap;
                  end else begin
                     r_state    <= StShift;
                     r_shift_dr <= 1'b1;
                     r_bsr_si   <= req_data[0];
                  end
               end
            end
            StCap: begin
               if (w_lo_last) begin
                  r_clock_dr <= 1'b1;
               end else if (w_hi_last) begin
                  r_clock_dr <= 1'b0;
                  r_shift_dr <= 1'b1;
                  r_bsr_si   <= r_shreg[0];
                  r_state    <= StShift;
               end
            end
            StShift: begin
               if (w_lo_last) begin
                  r_clock_dr <= 1'b1;
                  r_rsp_data <= (r_rsp_data >> 1) | w_bso_msb;
                  r_shreg    <= r_shreg >> 1;
               end else if (w_hi_last) begin
                  r_clock_dr <= 1'b0;
                  if (r_bit == LP_BIT_LAST) begin
                     r_shift_dr <= 1'b0;
                     r_bsr_si   <= 1'b0;
                     if (r_upd) begin
                        r_state     <= StUpd;
                        r_update_dr <= 1'b1;
`ifdef BW_IO_BSR_EXTEST_EN
                        r_mode_ctl  <= r_extest;
`endif
                     end else begin
                        r_state   <= StResp;
                        r_rsp_vld <= 1'b1;
                     end
                  end else begin
                     r_bit    <= r_bit + LP_BIT_ONE;
                     r_bsr_si <= r_shreg[0];
                  end
               end
            end
            StUpd: begin
               if (w_lo_last) begin
                  r_update_dr <= 1'b0;
               end else if (w_hi_last) begin
                  r_state   <= StResp;
                  r_rsp_vld <= 1'b1;
               end
            end
            StResp: begin
               if (rsp_rdy) begin
                  r_rsp_vld <= 1'b0;
                  r_req_rdy <= 1'b1;
                  r_state   <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign req_rdy   = r_req_rdy;
   assign rsp_vld   = r_rsp_vld;
   assign rsp_data  = r_rsp_data;
   assign shift_dr  = r_shift_dr;
   assign clock_dr  = r_clock_dr;
   assign update_dr = r_update_dr;
   assign bsr_si    = r_bsr_si;
`ifdef BW_IO_BSR_EXTEST_EN
   assign mode_ctl  = r_mode_ctl;
`else
   assign mode_ctl  = 1'b0;
`endif

endmodule

// File: tb/tb_bw_io_dtl_bsr_master.sv
// Directed bench for bw_io_dtl_bsr_master with an 8-cell BSR chain model (capture value 0xA5)
// plus a CHAIN_LEN=1/CLK_DIV=1 instance. Set BW_IO_BSR_EXTEST_EN to also cover mode_ctl.
module tb_bw_io_dtl_bsr_master;

   logic       clk = 1'b0;
   logic       reset_l = 1'b0;
   logic       req_vld = 1'b0, req_cap = 1'b0, req_upd = 1'b0, req_extest = 1'b0;
   logic [7:0] req_data = 8'h00;
   logic       rsp_rdy = 1'b0;
   logic       req_rdy, rsp_vld, shift_dr, clock_dr, update_dr, mode_ctl, bsr_si, bso;
   logic [7:0] rsp_data;

   logic       s_req_vld = 1'b0, s_req_cap = 1'b0, s_req_upd = 1'b0, s_rsp_rdy = 1'b0;
   logic [0:0] s_req_data = 1'b0;
   logic       s_req_rdy, s_rsp_vld, s_shift_dr, s_clock_dr, s_update_dr, s_mode_ctl, s_bsr_si;
   logic [0:0] s_rsp_data;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   bw_io_dtl_bsr_master #(
      .CHAIN_LEN (8),
      .CLK_DIV   (2)
   ) u_dut (
      .clk        (clk),
      .reset_l    (reset_l),
      .req_vld    (req_vld),
      .req_rdy    (req_rdy),
      .req_cap    (req_cap),
      .req_upd    (req_upd),
`ifdef BW_IO_BSR_EXTEST_EN
      .req_extest (req_extest),
`endif
      .req_data   (req_data),
      .rsp_vld    (rsp_vld),
      .rsp_rdy    (rsp_rdy),
      .rsp_data   (rsp_data),
      .shift_dr   (shift_dr),
      .clock_dr   (clock_dr),
      .update_dr  (update_dr),
      .mode_ctl   (mode_ctl),
      .bsr_si     (bsr_si),
      .bso        (bso)
   );

   bw_io_dtl_bsr_master #(
      .CHAIN_LEN (1),
      .CLK_DIV   (1)
   ) u_dut_small (
      .clk        (clk),
      .reset_l    (reset_l),
      .req_vld    (s_req_vld),
      .req_rdy    (s_req_rdy),
      .req_cap    (s_req_cap),
      .req_upd    (s_req_upd),
`ifdef BW_IO_BSR_EXTEST_EN
      .req_extest (1'b0),
`endif
      .req_data   (s_req_data),
      .rsp_vld    (s_rsp_vld),
      .rsp_rdy    (s_rsp_rdy),
      .rsp_data   (s_rsp_data),
      .shift_dr   (s_shift_dr),
      .clock_dr   (s_clock_dr),
      .update_dr  (s_update_dr),
      .mode_ctl   (s_mode_ctl),
      .bsr_si     (s_bsr_si),
      .bso        (1'b1)
   );

   // Chain model: si enters cell 7, bso is cell 0; capture loads 0xA5.
   logic [7:0] chain = 8'h00;
   logic [7:0] upd_latch = 8'h00;
   logic       p_ck = 1'b0, p_up = 1'b0, p_sh = 1'b0;
   int         n_shift = 0, n_cap = 0, n_upd = 0, n_overlap = 0, n_shchg = 0;

   assign bso = chain[0];

   always @(negedge clk) begin
      if (clock_dr && !p_ck) begin
         if (shift_dr) begin
            chain   = {bsr_si, chain[7:1]};
            n_shift = n_shift + 1;
         end else begin
            chain = 8'hA5;
            n_cap = n_cap + 1;
         end
      end
      if (update_dr && !p_up) begin
         upd_latch = chain;
         n_upd     = n_upd + 1;
      end
      if (clock_dr && update_dr) n_overlap = n_overlap + 1;
      if ((shift_dr != p_sh) && clock_dr) n_shchg = n_shchg + 1;
      p_ck = clock_dr;
      p_up = update_dr;
      p_sh = shift_dr;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one cycle; returns positioned in cycle 1 after acceptance.
   task automatic issue(input logic cap, input logic upd, input logic ext, input logic [7:0] d);
      req_cap    = cap;
      req_upd    = upd;
      req_extest = ext;
      req_data   = d;
      req_vld    = 1'b1;
      tick();
      req_vld    = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!rsp_vld && lat < 300) begin
         tick();
         lat++;
      end
   endtask

   task automatic handshake(input string tag);
      rsp_rdy = 1'b1;
      tick();
      rsp_rdy = 1'b0;
      check({tag, "_rsp_vld_clr"}, 32'(rsp_vld), 32'd0);
      check({tag, "_req_rdy_set"}, 32'(req_rdy), 32'd1);
   endtask

   int lat;
   int b_shift, b_cap, b_upd;

   initial begin
      // Reset state
      repeat (3) tick();
      check("rst_outputs", 32'({req_rdy, rsp_vld, shift_dr, clock_dr, update_dr, mode_ctl,
                                bsr_si}), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      reset_l = 1'b1;
      tick();
      check("rst_rdy_after_release", 32'(req_rdy), 32'd1);

      // Full capture/shift/update
      b_shift = n_shift; b_cap = n_cap; b_upd = n_upd;
      issue(1'b1, 1'b1, 1'b0, 8'h3C);
      check("full_busy_rdy", 32'(req_rdy), 32'd0);
      wait_rsp(lat);
      check("full_latency", 32'(lat), 32'd41);
      check("full_rsp_data", 32'(rsp_data), 32'hA5);
      check("full_upd_latch", 32'(upd_latch), 32'h3C);
      check("full_shift_rises", 32'(n_shift - b_shift), 32'd8);
      check("full_cap_rises", 32'(n_cap - b_cap), 32'd1);
      check("full_upd_pulses", 32'(n_upd - b_upd), 32'd1);
      check("full_mode_ctl", 32'(mode_ctl), 32'd0);
      check("resp_bsr_si_low", 32'(bsr_si), 32'd0);
      handshake("full");

      // Shift only
      b_shift = n_shift; b_cap = n_cap; b_upd = n_upd;
      issue(1'b0, 1'b0, 1'b0, 8'hFF);
      wait_rsp(lat);
      check("shonly_latency", 32'(lat), 32'd33);
      check("shonly_rsp_data", 32'(rsp_data), 32'h3C);
      check("shonly_upd_pulses", 32'(n_upd - b_upd), 32'd0);
      check("shonly_cap_rises", 32'(n_cap - b_cap), 32'd0);
      check("shonly_shift_rises", 32'(n_shift - b_shift), 32'd8);
      check("shonly_upd_latch", 32'(upd_latch), 32'h3C);
      handshake("shonly");

      // Back-to-back with the response held off; a pending request must wait
      issue(1'b1, 1'b0, 1'b0, 8'h0F);
      wait_rsp(lat);
      check("b2b_latency", 32'(lat), 32'd37);
      req_cap  = 1'b0;
      req_upd  = 1'b0;
      req_data = 8'h81;
      req_vld  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("b2b_hold_vld", 32'(rsp_vld), 32'd1);
         check("b2b_hold_data", 32'(rsp_data), 32'hA5);
         check("b2b_hold_rdy", 32'(req_rdy), 32'd0);
         tick();
      end
      handshake("b2b");
      tick();
      req_vld = 1'b0;
      wait_rsp(lat);
      check("b2b_second_latency", 32'(lat), 32'd33);
      check("b2b_second_data", 32'(rsp_data), 32'h0F);
      handshake("b2b2");

      // Reset in the middle of SHIFT bit 4
      b_upd = n_upd;
      issue(1'b0, 1'b1, 1'b0, 8'h55);
      repeat (17) tick();
      check("midrst_in_shift", 32'(shift_dr), 32'd1);
      reset_l = 1'b0;
      tick();
      check("midrst_outputs", 32'({req_rdy, rsp_vld, shift_dr, clock_dr, update_dr, mode_ctl,
                                   bsr_si}), 32'd0);
      check("midrst_rsp_data", 32'(rsp_data), 32'd0);
      tick();
      reset_l = 1'b1;
      tick();
      check("midrst_rdy_after_release", 32'(req_rdy), 32'd1);
      repeat (10) tick();
      check("midrst_no_update", 32'(n_upd - b_upd), 32'd0);
      check("midrst_upd_latch", 32'(upd_latch), 32'h3C);

      // Minimal chain and divider
      s_req_cap  = 1'b1;
      s_req_upd  = 1'b1;
      s_req_vld  = 1'b1;
      tick();
      s_req_vld  = 1'b0;
      lat = 1;
      while (!s_rsp_vld && lat < 50) begin
         tick();
         lat++;
      end
      check("small_latency", 32'(lat), 32'd7);
      check("small_rsp_data", 32'(s_rsp_data), 32'd1);
      s_rsp_rdy = 1'b1;
      tick();
      s_rsp_rdy = 1'b0;
      check("small_rdy_after", 32'(s_req_rdy), 32'd1);

`ifdef BW_IO_BSR_EXTEST_EN
      issue(1'b0, 1'b1, 1'b1, 8'h00);
      repeat (31) tick();
      check("extest_before_upd", 32'(mode_ctl), 32'd0);
      tick();
      check("extest_first_upd", 32'({update_dr, mode_ctl}), 32'd3);
      wait_rsp(lat);
      handshake("extest1");
      issue(1'b0, 1'b0, 1'b0, 8'h00);
      wait_rsp(lat);
      check("extest_kept", 32'(mode_ctl), 32'd1);
      handshake("extest2");
`endif

      check("never_clk_and_upd", 32'(n_overlap), 32'd0);
      check("shift_dr_only_clk_low", 32'(n_shchg), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
